// File: rtl/mprc_wb_data_reader.sv
// Writeback/release data reader: reads one victim line from the data array beat by beat
// and streams the beats to the release channel through a 2-entry response queue.
module mprc_wb_data_reader #(
  parameter  int BEATS = 4,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [5:0]           req_idx,
  input  logic [3:0]           req_way_en,
  input  logic [1:0]           req_client_xact_id,
  output logic                 data_read_valid,
  input  logic                 data_read_ready,
  output logic [3:0]           data_read_way_en,
  output logic [6+BW+4-1:0]    data_read_addr,
  input  logic [127:0]         data_resp_data,
  output logic                 release_valid,
  input  logic                 release_ready,
  output logic [BW-1:0]        release_addr_beat,
  output logic [127:0]         release_data,
  output logic [1:0]           release_client_xact_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic [BW-1:0] beat;
    logic [127:0]  data;
  } entry_t;

  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  state_t          state, state_nxt;
  logic [5:0]      idx;
  logic [3:0]      way;
  logic [1:0]      xid;
  logic [BW-1:0]   rd_beat, tx_beat;
  logic            inflight;
  logic [BW-1:0]   inflight_beat;
  entry_t [1:0]    q;
  logic            wptr, rptr;
  logic [1:0]      q_count;

  logic            rd_fire, push, pop, accept;
  logic [2:0]      occ;

  assign push    = inflight;
  assign pop     = release_valid & release_ready;
  assign rd_fire = data_read_valid & data_read_ready;
  assign accept  = req_valid & req_ready;

  // Slots already committed to queued or in-flight beats; a head leaving this
  // cycle frees its slot in time for a new read, which sustains one beat per cycle.
  assign occ = {1'b0, q_count} + {2'b0, inflight} - {2'b0, pop};

  always_comb begin
    state_nxt       = state;
    req_ready       = 1'b0;
    data_read_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = READ;
      end
      READ: begin
        data_read_valid = (occ < 3'd2);
        if (data_read_valid && data_read_ready && rd_beat == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && tx_beat == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      way           <= '0;
      xid           <= '0;
      rd_beat       <= '0;
      tx_beat       <= '0;
      inflight      <= 1'b0;
      inflight_beat <= '0;
      q             <= '0;
      wptr          <= 1'b0;
      rptr          <= 1'b0;
      q_count       <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_fire;
      if (rd_fire) begin
        rd_beat       <= rd_beat + 1'b1;
        inflight_beat <= rd_beat;
      end
      if (pop) begin
        tx_beat <= tx_beat + 1'b1;
        rptr    <= ~rptr;
      end
      if (push) begin
        q[wptr] <= '{beat: inflight_beat, data: data_resp_data};
        wptr    <= ~wptr;
      end
      q_count <= q_count + {1'b0, push} - {1'b0, pop};
      if (accept) begin
        idx     <= req_idx;
        way     <= req_way_en;
        xid     <= req_client_xact_id;
        rd_beat <= '0;
        tx_beat <= '0;
      end
    end
  end

  assign busy                   = (state != IDLE);
  assign data_read_way_en       = way;
  assign data_read_addr         = {idx, rd_beat, 4'h0};
  assign release_valid          = (q_count != 2'd0);
  assign release_data           = q[rptr].data;
  assign release_addr_beat      = q[rptr].beat;
  assign release_client_xact_id = xid;

  // A full queue with a response still in flight would drop a beat.
  assert property (@(posedge clk) disable iff (reset) !(q_count == 2'd2 && inflight));

endmodule

// File: tb/tb_mprc_wb_data_reader.sv
// Directed bench for mprc_wb_data_reader: cycle-exact checks of reads, releases and handshakes.
module tb_mprc_wb_data_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready;
  logic [5:0]   req_idx;
  logic [3:0]   req_way_en;
  logic [1:0]   req_client_xact_id;
  logic         data_read_valid, data_read_ready;
  logic [3:0]   data_read_way_en;
  logic [11:0]  data_read_addr;
  logic [127:0] data_resp_data;
  logic         release_valid, release_ready;
  logic [1:0]   release_addr_beat;
  logic [127:0] release_data;
  logic [1:0]   release_client_xact_id;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [5:0]  e_idx;
  logic [3:0]  e_way;
  logic [1:0]  e_id;
  logic [11:0] resp_addr = 12'hFFF;

  mprc_wb_data_reader #(.BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
    .req_way_en(req_way_en), .req_client_xact_id(req_client_xact_id),
    .data_read_valid(data_read_valid), .data_read_ready(data_read_ready),
    .data_read_way_en(data_read_way_en), .data_read_addr(data_read_addr),
    .data_resp_data(data_resp_data),
    .release_valid(release_valid), .release_ready(release_ready),
    .release_addr_beat(release_addr_beat), .release_data(release_data),
    .release_client_xact_id(release_client_xact_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [11:0] a);
    return {8{4'hC, a}};
  endfunction

  // Array model: data for an accepted read appears exactly one cycle later, garbage otherwise.
  always @(posedge clk) resp_addr <= (data_read_valid && data_read_ready) ? data_read_addr : 12'hFFF;
  assign data_resp_data = pat(resp_addr);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rdv, input logic [11:0] addr,
                     input logic relv, input logic [1:0] beat, input logic reqr);
    @(negedge clk);
    chk({tag, ":rd_valid"}, data_read_valid, rdv);
    if (rdv) begin
      chk({tag, ":rd_addr"}, data_read_addr, addr);
      chk({tag, ":rd_way"}, data_read_way_en, e_way);
    end
    chk({tag, ":rel_valid"}, release_valid, relv);
    if (relv) begin
      chk({tag, ":rel_beat"}, release_addr_beat, beat);
      chk({tag, ":rel_data"}, release_data, pat({e_idx, beat, 4'h0}));
      chk({tag, ":rel_id"}, release_client_xact_id, e_id);
    end
    chk({tag, ":req_ready"}, req_ready, reqr);
    chk({tag, ":busy"}, busy, !reqr);
    @(posedge clk); #1;
  endtask

  task automatic request(input logic [5:0] i, input logic [3:0] w, input logic [1:0] id);
    req_valid = 1'b1; req_idx = i; req_way_en = w; req_client_xact_id = id;
    e_idx = i; e_way = w; e_id = id;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_idx = '0; req_way_en = '0; req_client_xact_id = '0;
    data_read_ready = 1'b0; release_ready = 1'b0;
    e_idx = '0; e_way = '0; e_id = '0;
    #12;
    chk("rst:req_ready", req_ready, 1'b1);
    chk("rst:busy", busy, 1'b0);
    chk("rst:rd_valid", data_read_valid, 1'b0);
    chk("rst:rel_valid", release_valid, 1'b0);
    chk("rst:rd_addr", data_read_addr, 12'h000);
    chk("rst:rd_way", data_read_way_en, 4'h0);
    chk("rst:rel_data", release_data, 128'h0);
    chk("rst:rel_beat", release_addr_beat, 2'h0);
    chk("rst:rel_id", release_client_xact_id, 2'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic line, both channels always ready
    data_read_ready = 1'b1; release_ready = 1'b1;
    request(6'h2A, 4'b0100, 2'h1);
    cyc("basic0", 0, 12'h000, 0, 0, 1);
    req_valid = 1'b0;
    cyc("basic1", 1, 12'hA80, 0, 0, 0);
    cyc("basic2", 1, 12'hA90, 0, 0, 0);
    cyc("basic3", 1, 12'hAA0, 1, 0, 0);
    cyc("basic4", 1, 12'hAB0, 1, 1, 0);
    cyc("basic5", 0, 12'h000, 1, 2, 0);
    cyc("basic6", 0, 12'h000, 1, 3, 0);
    cyc("basic7", 0, 12'h000, 0, 0, 1);

    // Release backpressure for 10 cycles after accept
    release_ready = 1'b0;
    request(6'h15, 4'b0001, 2'h2);
    cyc("bp0", 0, 12'h000, 0, 0, 1);
    req_valid = 1'b0;
    cyc("bp1", 1, 12'h540, 0, 0, 0);
    cyc("bp2", 1, 12'h550, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc("bp_hold", 0, 12'h000, 1, 0, 0);
    release_ready = 1'b1;
    cyc("bp11", 1, 12'h560, 1, 0, 0);
    cyc("bp12", 1, 12'h570, 1, 1, 0);
    cyc("bp13", 0, 12'h000, 1, 2, 0);
    cyc("bp14", 0, 12'h000, 1, 3, 0);
    cyc("bp15", 0, 12'h000, 0, 0, 1);

    // Arbiter stall on beat 1; includes a same-cycle push and pop
    request(6'h2A, 4'b0100, 2'h3);
    cyc("st0", 0, 12'h000, 0, 0, 1);
    req_valid = 1'b0;
    cyc("st1", 1, 12'hA80, 0, 0, 0);
    data_read_ready = 1'b0;
    cyc("st2", 1, 12'hA90, 0, 0, 0);
    cyc("st3", 1, 12'hA90, 1, 0, 0);
    cyc("st4", 1, 12'hA90, 0, 0, 0);
    data_read_ready = 1'b1;
    cyc("st5", 1, 12'hA90, 0, 0, 0);
    cyc("st6", 1, 12'hAA0, 0, 0, 0);
    cyc("st7", 1, 12'hAB0, 1, 1, 0);
    cyc("st8", 0, 12'h000, 1, 2, 0);
    cyc("st9", 0, 12'h000, 1, 3, 0);
    cyc("st10", 0, 12'h000, 0, 0, 1);

    // Reset right after beat 1 is released
    request(6'h0F, 4'b0010, 2'h2);
    cyc("mr0", 0, 12'h000, 0, 0, 1);
    req_valid = 1'b0;
    cyc("mr1", 1, 12'h3C0, 0, 0, 0);
    cyc("mr2", 1, 12'h3D0, 0, 0, 0);
    cyc("mr3", 1, 12'h3E0, 1, 0, 0);
    cyc("mr4", 1, 12'h3F0, 1, 1, 0);
    reset = 1'b1;
    #1;
    chk("mr_rst:busy", busy, 1'b0);
    chk("mr_rst:rel_valid", release_valid, 1'b0);
    chk("mr_rst:rd_valid", data_read_valid, 1'b0);
    chk("mr_rst:req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    request(6'h0F, 4'b0010, 2'h1);
    cyc("ra0", 0, 12'h000, 0, 0, 1);
    req_valid = 1'b0;
    cyc("ra1", 1, 12'h3C0, 0, 0, 0);
    cyc("ra2", 1, 12'h3D0, 0, 0, 0);
    cyc("ra3", 1, 12'h3E0, 1, 0, 0);
    cyc("ra4", 1, 12'h3F0, 1, 1, 0);
    cyc("ra5", 0, 12'h000, 1, 2, 0);
    cyc("ra6", 0, 12'h000, 1, 3, 0);
    cyc("ra7", 0, 12'h000, 0, 0, 1);

    // Back-to-back requests with req_valid held high
    request(6'h01, 4'b1000, 2'h0);
    cyc("bb0", 0, 12'h000, 0, 0, 1);
    req_idx = 6'h02; req_way_en = 4'b0001; req_client_xact_id = 2'h3;
    cyc("bb1", 1, 12'h040, 0, 0, 0);
    cyc("bb2", 1, 12'h050, 0, 0, 0);
    cyc("bb3", 1, 12'h060, 1, 0, 0);
    cyc("bb4", 1, 12'h070, 1, 1, 0);
    cyc("bb5", 0, 12'h000, 1, 2, 0);
    cyc("bb6", 0, 12'h000, 1, 3, 0);
    cyc("bb7", 0, 12'h000, 0, 0, 1);
    req_valid = 1'b0;
    e_idx = 6'h02; e_way = 4'b0001; e_id = 2'h3;
    cyc("bb8", 1, 12'h080, 0, 0, 0);
    cyc("bb9", 1, 12'h090, 0, 0, 0);
    cyc("bb10", 1, 12'h0A0, 1, 0, 0);
    cyc("bb11", 1, 12'h0B0, 1, 1, 0);
    cyc("bb12", 0, 12'h000, 1, 2, 0);
    cyc("bb13", 0, 12'h000, 1, 3, 0);
    cyc("bb14", 0, 12'h000, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
